// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs
//   I2C target engine with an EEPROM-style register pointer interface.
//   - The first byte written after the address loads the pointer.
//   - Later written bytes are strobed out at the pointer.
//   - Read bytes are fetched from the pointer.
//   - The pointer auto-increments after every data byte.
//   There is no clock stretching and no general-call support.
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   i_scl, i_sda    asynchronous pin levels
//   o_sda_oen       SDA enable, active low (0 pulls the pin low)
//   o_reg_addr      register pointer
//   o_reg_wr_stb    one-cycle write strobe with o_reg_wr_data
//   o_reg_rd_stb    one-cycle read request; i_reg_rd_data is sampled one cycle later
//   o_busy          address-matched transfer in progress
//   o_start_det     one-cycle pulse on START / repeated START
//   o_stop_det      one-cycle pulse on STOP
module i2c_slave_regs #(
   parameter logic [6:0] I2C_ADDRESS  = 7'h50,
   parameter int         FILTER_DEPTH = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oen,
   output logic [7:0] o_reg_addr,
   output logic       o_reg_wr_stb,
   output logic [7:0] o_reg_wr_data,
   output logic       o_reg_rd_stb,
   input  logic [7:0] i_reg_rd_data,
   output logic       o_busy,
   output logic       o_start_det,
   output logic       o_stop_det
);

   localparam logic [2:0] FILT_LAST = 3'(FILTER_DEPTH - 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_WR_DATA,
      ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
   } state_t;

   logic       scl_meta_r, scl_sync_r, scl_f_r, scl_d_r;
   logic       sda_meta_r, sda_sync_r, sda_f_r, sda_d_r;
   logic [2:0] scl_cnt_r, sda_cnt_r;
   logic       scl_rise_s, scl_fall_s, start_s, stop_s;
   logic [7:0] byte_s;

   state_t     state_r, state_s;
   logic [3:0] bit_cnt_r, bit_cnt_s;
   logic [7:0] shift_r, shift_s;
   logic       rw_r, rw_s;
   logic [7:0] ptr_r, ptr_s;
   logic       oen_r, oen_s;
   logic       wr_stb_r, wr_stb_s;
   logic [7:0] wr_data_r, wr_data_s;
   logic       rd_stb_r, rd_stb_s;
   logic       rd_load_r;
   logic       busy_r, busy_s;
   logic       start_det_r, stop_det_r;

   // Pin synchronizers and level filters: a new level is accepted only after
   // FILTER_DEPTH consecutive samples that differ from the accepted level
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_meta_r <= 1'b1;
         scl_sync_r <= 1'b1;
         sda_meta_r <= 1'b1;
         sda_sync_r <= 1'b1;
         scl_f_r    <= 1'b1;
         sda_f_r    <= 1'b1;
         scl_d_r    <= 1'b1;
         sda_d_r    <= 1'b1;
         scl_cnt_r  <= 3'd0;
         sda_cnt_r  <= 3'd0;
      end else begin
         scl_meta_r <= i_scl;
         scl_sync_r <= scl_meta_r;
         sda_meta_r <= i_sda;
         sda_sync_r <= sda_meta_r;
         scl_d_r    <= scl_f_r;
         sda_d_r    <= sda_f_r;
         if (scl_sync_r != scl_f_r) begin
            if (scl_cnt_r == FILT_LAST) begin
               scl_f_r   <= scl_sync_r;
               scl_cnt_r <= 3'd0;
            end else begin
               scl_cnt_r <= scl_cnt_r + 3'd1;
            end
         end else begin
            scl_cnt_r <= 3'd0;
         end
         if (sda_sync_r != sda_f_r) begin
            if (sda_cnt_r == FILT_LAST) begin
               sda_f_r   <= sda_sync_r;
               sda_cnt_r <= 3'd0;
            end else begin
               sda_cnt_r <= sda_cnt_r + 3'd1;
            end
         end else begin
            sda_cnt_r <= 3'd0;
         end
      end
   end

   assign scl_rise_s = scl_f_r & ~scl_d_r;
   assign scl_fall_s = ~scl_f_r & scl_d_r;
   assign start_s    = scl_f_r & scl_d_r & sda_d_r & ~sda_f_r;
   assign stop_s     = scl_f_r & scl_d_r & ~sda_d_r & sda_f_r;
   assign byte_s     = {shift_r[6:0], sda_f_r};

   // Next-state and next-output logic. In the ACK states bit_cnt is 8 until
   // the ACK clock rises and 9 afterwards, which separates the falling edge
   // that starts the ACK from the one that ends it.
   always_comb begin
      state_s   = state_r;
      bit_cnt_s = bit_cnt_r;
      rw_s      = rw_r;
      oen_s     = oen_r;
      wr_stb_s  = 1'b0;
      wr_data_s = wr_data_r;
      rd_stb_s  = 1'b0;
      busy_s    = busy_r;
      // Write pointer advances the cycle after the write strobe
      if (wr_stb_r) begin
         ptr_s = ptr_r + 8'd1;
      end else begin
         ptr_s = ptr_r;
      end
      // Read data is captured the cycle after the read strobe
      if (rd_load_r) begin
         shift_s = i_reg_rd_data;
      end else begin
         shift_s = shift_r;
      end

      case (state_r)
         ST_ADDR, ST_PTR, ST_WR_DATA: begin
            if (scl_rise_s) begin
               shift_s   = byte_s;
               bit_cnt_s = bit_cnt_r + 4'd1;
               if (bit_cnt_r == 4'd7) begin
                  if (state_r == ST_ADDR) begin
                     if (byte_s[7:1] == I2C_ADDRESS) begin
                        state_s  = ST_ADDR_ACK;
                        rw_s     = byte_s[0];
                        rd_stb_s = byte_s[0];
                        busy_s   = 1'b1;
                     end else begin
                        state_s = ST_IGNORE;
                        oen_s   = 1'b1;
                        busy_s  = 1'b0;
                     end
                  end else if (state_r == ST_PTR) begin
                     state_s = ST_WR_ACK;
                     ptr_s   = byte_s;
                  end else begin
                     state_s   = ST_WR_ACK;
                     wr_stb_s  = 1'b1;
                     wr_data_s = byte_s;
                  end
               end else begin
                  state_s = state_r;
               end
            end else begin
               state_s = state_r;
            end
         end
         ST_ADDR_ACK, ST_WR_ACK: begin
            if (scl_fall_s) begin
               if (bit_cnt_r == 4'd8) begin
                  oen_s = 1'b0;
               end else begin
                  bit_cnt_s = 4'd0;
                  if (state_r == ST_WR_ACK) begin
                     state_s = ST_WR_DATA;
                     oen_s   = 1'b1;
                  end else if (rw_r) begin
                     state_s = ST_RD_DATA;
                     oen_s   = shift_r[7];
                  end else begin
                     state_s = ST_PTR;
                     oen_s   = 1'b1;
                  end
               end
            end else if (scl_rise_s) begin
               bit_cnt_s = 4'd9;
            end else begin
               bit_cnt_s = bit_cnt_r;
            end
         end
         ST_RD_DATA: begin
            if (scl_rise_s) begin
               bit_cnt_s = bit_cnt_r + 4'd1;
            end else if (scl_fall_s) begin
               if (bit_cnt_r == 4'd8) begin
                  state_s = ST_RD_ACK;
                  oen_s   = 1'b1;
               end else begin
                  oen_s   = shift_r[6];
                  shift_s = {shift_r[6:0], 1'b0};
               end
            end else begin
               bit_cnt_s = bit_cnt_r;
            end
         end
         ST_RD_ACK: begin
            if (scl_rise_s) begin
               ptr_s = ptr_r + 8'd1;
               if (!sda_f_r) begin
                  rd_stb_s  = 1'b1;
                  bit_cnt_s = 4'd9;
               end else begin
                  state_s = ST_IGNORE;
                  busy_s  = 1'b0;
               end
            end else if (scl_fall_s && (bit_cnt_r == 4'd9)) begin
               state_s   = ST_RD_DATA;
               bit_cnt_s = 4'd0;
               oen_s     = shift_r[7];
            end else begin
               state_s = state_r;
            end
         end
         ST_IDLE, ST_IGNORE: begin
            oen_s = 1'b1;
         end
         default: begin
            state_s = ST_IDLE;
            oen_s   = 1'b1;
         end
      endcase

      // Bus conditions override whatever the current state decided
      if (stop_s) begin
         state_s = ST_IDLE;
         oen_s   = 1'b1;
         busy_s  = 1'b0;
      end else if (start_s) begin
         state_s   = ST_ADDR;
         bit_cnt_s = 4'd0;
         oen_s     = 1'b1;
      end else begin
         state_s = state_s;
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         bit_cnt_r   <= 4'd0;
         shift_r     <= 8'd0;
         rw_r        <= 1'b0;
         ptr_r       <= 8'd0;
         oen_r       <= 1'b1;
         wr_stb_r    <= 1'b0;
         wr_data_r   <= 8'd0;
         rd_stb_r    <= 1'b0;
         rd_load_r   <= 1'b0;
         busy_r      <= 1'b0;
         start_det_r <= 1'b0;
         stop_det_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         bit_cnt_r   <= bit_cnt_s;
         shift_r     <= shift_s;
         rw_r        <= rw_s;
         ptr_r       <= ptr_s;
         oen_r       <= oen_s;
         wr_stb_r    <= wr_stb_s;
         wr_data_r   <= wr_data_s;
         rd_stb_r    <= rd_stb_s;
         rd_load_r   <= rd_stb_r;
         busy_r      <= busy_s;
         start_det_r <= start_s;
         stop_det_r  <= stop_s;
      end
   end

   assign o_sda_oen     = oen_r;
   assign o_reg_addr    = ptr_r;
   assign o_reg_wr_stb  = wr_stb_r;
   assign o_reg_wr_data = wr_data_r;
   assign o_reg_rd_stb  = rd_stb_r;
   assign o_busy        = busy_r;
   assign o_start_det   = start_det_r;
   assign o_stop_det    = stop_det_r;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Testbench for i2c_slave_regs: a bit-level I2C master drives the bus, a
// reference register-file model predicts strobes and read bytes, and a
// negedge monitor pops the expected strobes as the DUT issues them.
module tb_i2c_slave_regs;

   localparam int         Q        = 10;     // clk cycles per quarter SCL period
   localparam logic [6:0] DUT_ADDR = 7'h50;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m;
   logic       sda_bus;
   logic       o_sda_oen, o_reg_wr_stb, o_reg_rd_stb, o_busy, o_start_det, o_stop_det;
   logic [7:0] o_reg_addr, o_reg_wr_data, i_reg_rd_data;

   always #5 clk = ~clk;
   assign sda_bus = sda_m & o_sda_oen;

   i2c_slave_regs #(.I2C_ADDRESS(DUT_ADDR), .FILTER_DEPTH(3)) dut (
      .clk(clk), .rst(rst), .i_scl(scl_m), .i_sda(sda_bus),
      .o_sda_oen(o_sda_oen), .o_reg_addr(o_reg_addr), .o_reg_wr_stb(o_reg_wr_stb),
      .o_reg_wr_data(o_reg_wr_data), .o_reg_rd_stb(o_reg_rd_stb),
      .i_reg_rd_data(i_reg_rd_data), .o_busy(o_busy),
      .o_start_det(o_start_det), .o_stop_det(o_stop_det)
   );

   int n_checks = 0, n_fail = 0;
   int start_seen = 0, stop_seen = 0, start_exp = 0, stop_exp = 0;
   int n_wr_seen = 0, n_wr_exp = 0, n_rd_seen = 0, n_rd_exp = 0, sda_low_cnt = 0;

   logic [15:0] wr_q[$];       // expected {addr, data} of write strobes
   logic [7:0]  rd_q[$];       // expected addr of read strobes
   logic [7:0]  wdata_q[$];    // data bytes for the next write transaction
   logic [7:0]  mem_m[256];    // reference register contents
   logic [7:0]  ptr_m;         // reference pointer
   logic [7:0]  regfile[256];  // local register file played by the bench
   logic [15:0] mon_wr;
   logic [7:0]  mon_rd, rd_hold;
   logic        rd_phase = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: scoreboard for strobes, local register file, pulse counters
   always @(negedge clk) begin
      if (o_start_det === 1'b1) start_seen++;
      if (o_stop_det === 1'b1) stop_seen++;
      if (o_sda_oen === 1'b0) sda_low_cnt++;
      if (o_reg_wr_stb === 1'b1) begin
         n_wr_seen++;
         check("wr_stb_expected", 32'(wr_q.size() > 0), 32'd1);
         if (wr_q.size() > 0) begin
            mon_wr = wr_q.pop_front();
            check("wr_addr_data", {o_reg_addr, o_reg_wr_data}, mon_wr);
         end
         regfile[o_reg_addr] = o_reg_wr_data;
      end
      // Read data is valid only around the sampling cycle after the strobe
      if (o_reg_rd_stb === 1'b1) begin
         n_rd_seen++;
         check("rd_stb_expected", 32'(rd_q.size() > 0), 32'd1);
         if (rd_q.size() > 0) begin
            mon_rd = rd_q.pop_front();
            check("rd_addr", o_reg_addr, mon_rd);
         end
         rd_hold       = o_reg_addr;
         rd_phase      = 1'b1;
         i_reg_rd_data = 8'($urandom);
      end else if (rd_phase) begin
         i_reg_rd_data = regfile[rd_hold];
         rd_phase      = 1'b0;
      end else begin
         i_reg_rd_data = 8'($urandom);
      end
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clock_bit(input logic b, output logic r);
      sda_m = b;
      wait_clk(Q);
      scl_m = 1'b1;
      wait_clk(Q);
      r = sda_bus;
      wait_clk(Q);
      scl_m = 1'b0;
      wait_clk(Q);
   endtask

   task automatic bus_start();
      start_exp++;
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      stop_exp++;
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b1; wait_clk(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, r);
         d[i] = r;
      end
      clock_bit(nack, r);
   endtask

   task automatic finish_tx();
      check("busy_after_stop", o_busy, 1'b0);
      check("pointer", o_reg_addr, ptr_m);
      check("start_count", start_seen, start_exp);
      check("stop_count", stop_seen, stop_exp);
   endtask

   // Write transaction: address, pointer byte, then every byte in wdata_q
   task automatic do_write(input logic [6:0] a7, input logic [7:0] p);
      logic ack, hit;
      int   snap;
      hit  = (a7 == DUT_ADDR);
      snap = sda_low_cnt;
      bus_start();
      write_byte({a7, 1'b0}, ack);
      check("addr_ack", ack, !hit);
      check("busy_after_addr", o_busy, hit);
      write_byte(p, ack);
      check("ptr_ack", ack, !hit);
      if (hit) ptr_m = p;
      foreach (wdata_q[i]) begin
         if (hit) begin
            wr_q.push_back({ptr_m, wdata_q[i]});
            n_wr_exp++;
            mem_m[ptr_m] = wdata_q[i];
            ptr_m++;
         end
         write_byte(wdata_q[i], ack);
         check("data_ack", ack, !hit);
      end
      bus_stop();
      if (!hit) check("no_sda_drive", sda_low_cnt - snap, 0);
      finish_tx();
   endtask

   // Pointer write, repeated START, read n bytes (ACK all but the last)
   task automatic do_read(input logic [7:0] p, input int n);
      logic       ack;
      logic [7:0] d;
      bus_start();
      write_byte(8'hA0, ack);
      check("rd_addr_w_ack", ack, 1'b0);
      write_byte(p, ack);
      check("rd_ptr_ack", ack, 1'b0);
      ptr_m = p;
      bus_start();
      rd_q.push_back(ptr_m);
      n_rd_exp++;
      write_byte(8'hA1, ack);
      check("rd_addr_r_ack", ack, 1'b0);
      for (int k = 0; k < n; k++) begin
         if (k < n - 1) begin
            rd_q.push_back(ptr_m + 8'd1);
            n_rd_exp++;
         end
         read_byte(k == n - 1, d);
         check("rd_byte", d, mem_m[ptr_m]);
         ptr_m++;
      end
      bus_stop();
      finish_tx();
   endtask

   initial begin
      logic       ack, r;
      logic [6:0] a7;
      int         snap, kind;

      for (int i = 0; i < 256; i++) begin
         mem_m[i]   = 8'(i) ^ 8'hFF;
         regfile[i] = 8'(i) ^ 8'hFF;
      end
      ptr_m = 8'd0;
      i_reg_rd_data = 8'd0;
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
      wait_clk(5);
      check("rst_oen", o_sda_oen, 1'b1);
      check("rst_addr", o_reg_addr, 8'd0);
      check("rst_wr_data", o_reg_wr_data, 8'd0);
      check("rst_strobes", {o_reg_wr_stb, o_reg_rd_stb, o_start_det, o_stop_det}, 4'd0);
      check("rst_busy", o_busy, 1'b0);
      rst = 1'b0;
      wait_clk(10);

      // Two-byte write
      wdata_q = '{8'h55, 8'hAA};
      do_write(DUT_ADDR, 8'h10);
      check("write_final_ptr", o_reg_addr, 8'h12);

      // Read with repeated START: bytes 0xDF, 0xDE
      do_read(8'h20, 2);
      check("read_final_ptr", o_reg_addr, 8'h22);

      // Address mismatch
      wdata_q = '{};
      do_write(7'h51, 8'h33);

      // Pointer wrap
      wdata_q = '{8'h01, 8'h02, 8'h03};
      do_write(DUT_ADDR, 8'hFF);

      // Glitch rejection: 2-cycle SDA low pulse with SCL high
      snap = start_seen;
      @(negedge clk); sda_m = 1'b0;
      @(negedge clk); @(negedge clk); sda_m = 1'b1;
      wait_clk(12);
      check("glitch_no_start", start_seen, snap);
      check("glitch_busy", o_busy, 1'b0);
      check("glitch_oen", o_sda_oen, 1'b1);

      // Randomized transactions
      for (int t = 0; t < 12; t++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0) begin
            wdata_q = '{};
            repeat ($urandom_range(1, 4)) wdata_q.push_back(8'($urandom));
            do_write(DUT_ADDR, 8'($urandom));
         end else if (kind == 1) begin
            do_read(8'($urandom), $urandom_range(1, 3));
         end else begin
            a7 = 7'($urandom);
            while (a7 == DUT_ADDR) a7 = 7'($urandom);
            wdata_q = '{8'($urandom)};
            do_write(a7, 8'($urandom));
         end
      end

      // Reset while the DUT drives a 0 read bit
      wdata_q = '{8'h00};
      do_write(DUT_ADDR, 8'h3C);
      wdata_q = '{};
      do_write(DUT_ADDR, 8'h3C);
      bus_start();
      rd_q.push_back(ptr_m);
      n_rd_exp++;
      write_byte(8'hA1, ack);
      check("mid_read_ack", ack, 1'b0);
      for (int i = 0; i < 20 && o_sda_oen !== 1'b0; i++) @(negedge clk);
      check("mid_read_driving", o_sda_oen, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("reset_release_oen", o_sda_oen, 1'b1);
      rst = 1'b0;
      check("reset_ptr", o_reg_addr, 8'd0);
      check("reset_busy", o_busy, 1'b0);
      ptr_m = 8'd0;
      snap = sda_low_cnt;
      for (int i = 0; i < 3; i++) begin
         clock_bit(1'b1, r);
         check("idle_no_drive", r, 1'b1);
      end
      bus_stop();
      check("reset_no_drive", sda_low_cnt - snap, 0);
      finish_tx();

      check("wr_strobe_total", n_wr_seen, n_wr_exp);
      check("rd_strobe_total", n_rd_seen, n_rd_exp);
      check("wr_q_empty", wr_q.size(), 0);
      check("rd_q_empty", rd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C target (slave) engine that answers a bus master, such as the team's AXI-lite I2C master core, and exposes an 8-bit register-pointer style interface to local logic. It follows the common EEPROM-style register model:
- first data byte after a write address sets the register pointer;
- following writes store bytes at the pointer;
- reads return bytes from the pointer;
- the pointer auto-increments after each data byte.

It sits between the open-drain pad logic and a local register file. It has no clock stretching and no general-call support.

## Interface
- I2C_ADDRESS, 7'h50, 7-bit target address this block responds to
- FILTER_DEPTH, 3, consecutive equal samples required before a synchronized SCL/SDA level change is accepted (1..7)
- clk  input  1  system clock; must be at least 25x SCL frequency
- rst  input  1  synchronous, active-high reset
- i_scl  input  1  SCL pin level (asynchronous)
- i_sda  input  1  SDA pin level (asynchronous)
- o_sda_oen  output  1  SDA output enable, active low: 0 drives the pin low, 1 releases it. The pad drives 0 when enabled.
- o_reg_addr  output  8  current register pointer
- o_reg_wr_stb  output  1  one-cycle write strobe; o_reg_addr and o_reg_wr_data are valid during it
- o_reg_wr_data  output  8  received data byte
- o_reg_rd_stb  output  1  one-cycle read request for the byte at o_reg_addr
- i_reg_rd_data  input  8  read byte; sampled exactly 1 cycle after o_reg_rd_stb
- o_busy  output  1  high from an address-matched START until STOP or NACK
- o_start_det  output  1  one-cycle pulse on each START or repeated START
- o_stop_det  output  1  one-cycle pulse on each STOP

## Operation
- **Input conditioning:** 2-flop synchronizer on each pin, then the FILTER_DEPTH filter. All detection below uses the filtered levels only.
- **START:** SDA falls while SCL is high. **STOP:** SDA rises while SCL is high.
- **Bit timing:** bits are sampled on the SCL rising edge. The SDA drive changes only on an SCL falling edge.
- **State machine:** IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- **START / repeated START:** from any state, go to ADDR and clear the bit counter. The pointer is retained.
- **STOP:** from any state, go to IDLE, release SDA, drop o_busy.
- **ADDR:** shift 8 bits, MSB first.
  - On match of bits [7:1] with I2C_ADDRESS: go to ADDR_ACK and drive ACK (SDA low) for the 9th clock.
  - On mismatch: go to IGNORE and release SDA.
- **ADDR_ACK, R/W=0:** go to PTR.
- **ADDR_ACK, R/W=1:** pulse o_reg_rd_stb on the SCL rise of the 8th bit and load the shift register next cycle. Bit 7 is driven on the falling edge that ends the ACK, then go to RD_DATA.
- **PTR:** the 8 received bits load the pointer. ACK the byte, then go to WR_DATA. No write strobe is issued.
- **WR_DATA:** after 8 bits, pulse o_reg_wr_stb with the current pointer. The pointer increments the following cycle. ACK the byte, then return to WR_DATA.
- **RD_DATA:** shift out 8 bits, then release SDA for the master's ACK bit (RD_ACK).
  - The pointer increments on the 9th SCL rise whether the master sent ACK or NACK.
  - Master ACK (SDA low): pulse o_reg_rd_stb and reload; next byte.
  - Master NACK: go to IGNORE.
- **IGNORE:** SDA stays released; wait for START or STOP.
- **Pointer arithmetic:** 8 bits, wraps 8'hFF -> 8'h00.
- **SDA released when driving 1:** a read data bit of 1 means o_sda_oen=1. No arbitration or contention check is made.

## Timing
- **Reset values:** o_sda_oen=1; o_reg_addr=0; o_reg_wr_data=0; all strobes 0; o_busy=0; state IDLE.
- **Reset mid-transfer:** SDA is released on the cycle after rst is sampled high.
- **Filter latency:** filtered levels lag the pins by 2+FILTER_DEPTH clk cycles. Any pulse shorter than FILTER_DEPTH cycles is rejected.
- **Write strobe latency:** o_reg_wr_stb is asserted 1 cycle after the filtered 8th SCL rise.
- **Output changes:** o_sda_oen changes 1 cycle after a filtered SCL fall.
- **Read-data hold:** read data must be stable on i_reg_rd_data during the cycle after o_reg_rd_stb. Local logic gets no other wait.
- **Simultaneous STOP with a pending strobe:** any strobe already due is still issued. STOP takes effect in the same cycle.
- **Strobe spacing:** each strobe is at most one cycle per byte, never back-to-back within a byte.

## Test plan
- **Write, two data bytes:** START, 0xA0, 0x10, 0x55, 0xAA, STOP -> four ACKs on the bus; wr_stb (addr 0x10, data 0x55), then wr_stb (0x11, 0xAA); final pointer 0x12; o_stop_det pulses.
- **Read with repeated START:** START, 0xA0, 0x20, rSTART, 0xA1, read 2 bytes (ACK then NACK), STOP; i_reg_rd_data returns addr XOR 0xFF -> bus bytes 0xDF, 0xDE; two rd_stb pulses at 0x20 and 0x21; pointer 0x22.
- **Address mismatch:** START, 0xA2, 0x33, STOP -> SDA never driven low; no strobes; o_busy stays 0.
- **Pointer wrap:** write pointer 0xFF, then 3 data bytes -> wr_stb addresses 0xFF, 0x00, 0x01.
- **Glitch rejection:** with SCL high, a 2-cycle SDA low pulse (FILTER_DEPTH=3) -> no o_start_det and no state change.
- **Reset mid-read:** assert rst while driving a 0 data bit -> o_sda_oen=1 next cycle; state IDLE; pointer 0.
